// File: rtl/mc_ctrl.sv
// Multi-cycle IF/ID/EXE/MEM/WB sequencer for the LoongArch core.
// Handshakes with the instruction/data SRAMs through inst_ok/data_ok,
// halts with a sticky error flag when a memory stalls too long, and
// keeps free-running cycle and retired-instruction counters.
module mc_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16,
    parameter int WAIT_W  = 5
) (
    input  logic             clk,
    input  logic             resetn,
    output logic             inst_req,
    input  logic             inst_ok,
    output logic             ir_we,
    input  logic             op_branch,
    input  logic             op_load,
    input  logic             op_store,
    input  logic             op_link,
    input  logic             op_wb,
    input  logic             br_taken,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             data_req,
    output logic             data_wr,
    input  logic             data_ok,
    output logic             rf_we,
    output logic             retire,
    output logic [2:0]       state,
    output logic             err,
    output logic [CNT_W-1:0] cycles,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd7
    } state_t;

    // The last wait count before a timeout; only meaningful when TIMEOUT != 0.
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
    localparam bit                TIMEOUT_EN = (TIMEOUT != 0);

    state_t            cur_state;
    state_t            nxt_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] nxt_wait;
    logic              set_err;
    logic              wait_hit;

    // Decoded op classes resolved by priority: branch > load > store > link > wb.
    logic is_branch;
    logic is_load;
    logic is_store;
    logic is_link;
    logic is_wb;

    assign is_branch = op_branch;
    assign is_load   = op_load  & ~op_branch;
    assign is_store  = op_store & ~op_load & ~op_branch;
    assign is_link   = op_link  & ~op_store & ~op_load & ~op_branch;
    assign is_wb     = op_wb    & ~op_link & ~op_store & ~op_load & ~op_branch;

    assign wait_hit = TIMEOUT_EN && (wait_cnt == WAIT_LAST);
    assign state    = cur_state;

    // Next-state and strobe decode; strobes are suppressed while in reset.
    always_comb begin
        nxt_state = cur_state;
        nxt_wait  = '0;
        set_err   = 1'b0;
        inst_req  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 1'b0;
        data_req  = 1'b0;
        data_wr   = 1'b0;
        rf_we     = 1'b0;
        retire    = 1'b0;

        case (cur_state)
            S_IF: begin
                inst_req = 1'b1;
                if (inst_ok) begin
                    ir_we     = 1'b1;
                    nxt_state = S_ID;
                end else if (wait_hit) begin
                    nxt_state = S_HALT;
                    set_err   = 1'b1;
                end else begin
                    nxt_wait = wait_cnt + WAIT_W'(1);
                end
            end
            S_ID: begin
                if (is_branch) begin
                    pc_we     = 1'b1;
                    pc_sel    = br_taken;
                    retire    = 1'b1;
                    nxt_state = S_IF;
                end else begin
                    nxt_state = S_EXE;
                end
            end
            S_EXE: begin
                if (is_load || is_store) begin
                    nxt_state = S_MEM;
                end else if (is_link || is_wb) begin
                    nxt_state = S_WB;
                end else begin
                    pc_we     = 1'b1;
                    retire    = 1'b1;
                    nxt_state = S_IF;
                end
            end
            S_MEM: begin
                data_req = 1'b1;
                data_wr  = is_store;
                if (data_ok) begin
                    if (is_load) begin
                        nxt_state = S_WB;
                    end else begin
                        pc_we     = 1'b1;
                        retire    = 1'b1;
                        nxt_state = S_IF;
                    end
                end else if (wait_hit) begin
                    nxt_state = S_HALT;
                    set_err   = 1'b1;
                end else begin
                    nxt_wait = wait_cnt + WAIT_W'(1);
                end
            end
            S_WB: begin
                rf_we     = 1'b1;
                pc_we     = 1'b1;
                pc_sel    = is_link & br_taken;
                retire    = 1'b1;
                nxt_state = S_IF;
            end
            S_HALT: begin
                nxt_state = S_HALT;
            end
            default: begin
                nxt_state = S_IF;
            end
        endcase

        if (!resetn) begin
            inst_req = 1'b0;
            ir_we    = 1'b0;
            pc_we    = 1'b0;
            pc_sel   = 1'b0;
            data_req = 1'b0;
            data_wr  = 1'b0;
            rf_we    = 1'b0;
            retire   = 1'b0;
        end
    end

    // State, wait counter, sticky error and performance counters.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cur_state <= S_IF;
            wait_cnt  <= '0;
            err       <= 1'b0;
            cycles    <= '0;
            instret   <= '0;
        end else begin
            cur_state <= nxt_state;
            wait_cnt  <= nxt_wait;
            if (set_err) begin
                err <= 1'b1;
            end
            if (cur_state != S_HALT) begin
                cycles <= cycles + CNT_W'(1);
            end
            if (retire) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

endmodule
